pipe_ctrl: RTL

Pipeline control unit for the five-stage Y86-64 core. It drives the stall and bubble controls of the F, D, E, M and W pipeline registers (including the F→D decode register) for load/use hazards, `ret` processing and mispredicted jumps. It also gates condition-code updates on exceptions and runs a run/halt state machine that freezes the pipeline once an exception or `halt` reaches write-back. Free-running performance counters are provided for debug and verification.

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Y86-64 five-stage pipeline control. Generates stall/bubble
//            controls for load/use, ret and mispredict hazards, gates the
//            condition-code write on exceptions, runs a RUN/HALTED machine
//            and keeps free-running performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] bub_cnt
);

    // Instruction codes used by the hazard logic
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_REG_NONE = 4'hF;

    // Status codes
    localparam logic [2:0] c_S_BUB = 3'd0;
    localparam logic [2:0] c_S_AOK = 3'd1;

    // Run/halt state encoding
    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_HALTED = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [2:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;
    logic [CNT_W-1:0] r_bub_cnt;

    logic w_load_use;
    logic w_ret_pend;
    logic w_mispred;
    logic w_m_exc;
    logic w_w_exc;
    logic w_run;
    logic w_use_run_eq;

    // Exception status: HLT, ADR or INS
    function automatic logic f_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    // W_icode is part of the pipeline interface but no control depends on it
    logic w_unused;
    assign w_unused = ^W_icode;

    assign w_load_use = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
                        (E_dstM != c_REG_NONE) &&
                        ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_ret_pend = (D_icode == c_I_RET) || (E_icode == c_I_RET) ||
                        (M_icode == c_I_RET);
    assign w_mispred  = (E_icode == c_I_JXX) && !e_Cnd;
    assign w_m_exc    = f_exc(m_stat);
    assign w_w_exc    = f_exc(W_stat);
    assign w_run      = (r_state == c_ST_RUN);
    // While reset is held the RUN equations apply even if currently halted
    assign w_use_run_eq = w_run || reset;

    // Hazard controls: RUN equations, or a full freeze when halted
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        if (w_use_run_eq) begin
            F_stall  = w_load_use | w_ret_pend;
            D_stall  = w_load_use;
            // load/use holds D, so it suppresses only the ret bubble
            D_bubble = w_mispred | (w_ret_pend & !w_load_use);
            E_bubble = w_mispred | w_load_use;
            M_bubble = w_m_exc | w_w_exc;
            W_stall  = w_w_exc;
            set_cc   = (E_icode == c_I_OPQ) && !w_m_exc && !w_w_exc;
        end
    end

    // Run/halt machine with latched status; reset wins over the halt edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_RUN;
            r_cpu_stat <= c_S_AOK;
        end else if (w_run && w_w_exc) begin
            r_state    <= c_ST_HALTED;
            r_cpu_stat <= W_stat;
        end
    end

    // Performance counters advance only in RUN and wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
            r_lu_cnt  <= '0;
            r_mp_cnt  <= '0;
            r_bub_cnt <= '0;
        end else if (w_run) begin
            r_cyc_cnt <= r_cyc_cnt + c_CNT_ONE;
            if (w_ret_pend && F_stall) r_ret_cnt <= r_ret_cnt + c_CNT_ONE;
            if (w_load_use)            r_lu_cnt  <= r_lu_cnt + c_CNT_ONE;
            if (w_mispred)             r_mp_cnt  <= r_mp_cnt + c_CNT_ONE;
            if (W_stat == c_S_BUB)     r_bub_cnt <= r_bub_cnt + c_CNT_ONE;
        end
    end

    assign cpu_stat = r_cpu_stat;
    assign halted   = (r_state == c_ST_HALTED);
    assign cyc_cnt  = r_cyc_cnt;
    assign ret_cnt  = r_ret_cnt;
    assign lu_cnt   = r_lu_cnt;
    assign mp_cnt   = r_mp_cnt;
    assign bub_cnt  = r_bub_cnt;

endmodule
`default_nettype wire
